// File: rtl/hazard_stall_controller_pkg.sv
// Shared types for the hazard stall controller: FSM encoding, counter width,
// stall-cause enumeration and the latency-to-count load helper.
package hazard_stall_controller_pkg;

  localparam int unsigned COUNT_W = 6;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    LOADUSE = 2'd1,
    MULDIV  = 2'd2,
    MEM     = 2'd3
  } stall_cause_e;

  // The first stall cycle is spent in IDLE, so the counter starts at L-2.
  function automatic logic [COUNT_W-1:0] md_count_load(input int unsigned latency);
    logic [COUNT_W-1:0] load_s;
    if (latency > 32'd1) begin
      load_s = COUNT_W'(latency - 32'd2);
    end else begin
      load_s = {COUNT_W{1'b0}};
    end
    return load_s;
  endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Pipeline-to-stall-controller bundle: hazard observations in, hold/flush out.
interface hazard_stall_controller_if;

  logic [4:0] id_addr1;
  logic [4:0] id_addr2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       ex_mem_read;
  logic [4:0] ex_wb_addr;
  logic       ex_muldiv_valid;
  logic       ex_muldiv_is_div;
  logic       mem_busy;

  logic       pc_hold;
  logic       ifid_hold;
  logic       idex_hold;
  logic       idex_flush;
  logic       exmem_hold;
  logic       exmem_flush;
  logic       memwb_flush;
  logic       muldiv_done;

  modport master (
    output id_addr1, id_addr2, id_uses_rs1, id_uses_rs2,
           ex_mem_read, ex_wb_addr, ex_muldiv_valid, ex_muldiv_is_div, mem_busy,
    input  pc_hold, ifid_hold, idex_hold, idex_flush,
           exmem_hold, exmem_flush, memwb_flush, muldiv_done
  );

  modport slave (
    input  id_addr1, id_addr2, id_uses_rs1, id_uses_rs2,
           ex_mem_read, ex_wb_addr, ex_muldiv_valid, ex_muldiv_is_div, mem_busy,
    output pc_hold, ifid_hold, idex_hold, idex_flush,
           exmem_hold, exmem_flush, memwb_flush, muldiv_done
  );

endinterface

// File: rtl/hazard_stall_controller_muldiv_latency_counter.sv
// Down-counter tracking remaining RV32M occupancy of EX; freezes while the
// data memory stalls the whole pipeline.
module muldiv_latency_counter
  import hazard_stall_controller_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               freeze,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [COUNT_W-1:0] count_r;

  // Count register: reset, freeze, load, decrement, in that priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {COUNT_W{1'b0}};
    end else if (freeze) begin
      count_r <= count_r;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec) begin
      count_r <= count_r - {{(COUNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {COUNT_W{1'b0}});

endmodule

// File: rtl/hazard_stall_controller.sv
// Stall/bubble sequencer for the 5-stage RV32IM pipeline (memory wait, RV32M
// occupancy, load-use). Optional perf counters: define STALL_PERF_CNT_EN.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 1,
  parameter int unsigned DIV_LATENCY = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  hazard_stall_controller_if.slave  hz
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]               loaduse_stall_cnt,
  output logic [31:0]               muldiv_stall_cnt,
  output logic [31:0]               mem_stall_cnt
`endif
);

  localparam logic [COUNT_W-1:0] MUL_LOAD  = md_count_load(MUL_LATENCY);
  localparam logic [COUNT_W-1:0] DIV_LOAD  = md_count_load(DIV_LATENCY);
  localparam logic               MUL_MULTI = (MUL_LATENCY > 32'd1);
  localparam logic               DIV_MULTI = (DIV_LATENCY > 32'd1);

  md_state_e          state_r;
  md_state_e          state_nxt_s;
  stall_cause_e       cause_s;
  logic               load_use_s;
  logic               md_multi_s;
  logic [COUNT_W-1:0] md_load_val_s;
  logic               cnt_load_s;
  logic               cnt_dec_s;
  logic               cnt_zero_s;

  logic pc_hold_s, ifid_hold_s, idex_hold_s, idex_flush_s;
  logic exmem_hold_s, exmem_flush_s, memwb_flush_s, muldiv_done_s;

  assign load_use_s = hz.ex_mem_read && (hz.ex_wb_addr != 5'd0) &&
                      ((hz.id_uses_rs1 && (hz.id_addr1 == hz.ex_wb_addr)) ||
                       (hz.id_uses_rs2 && (hz.id_addr2 == hz.ex_wb_addr)));

  assign md_multi_s    = hz.ex_muldiv_is_div ? DIV_MULTI : MUL_MULTI;
  assign md_load_val_s = hz.ex_muldiv_is_div ? DIV_LOAD  : MUL_LOAD;

  muldiv_latency_counter u_md_cnt (
    .clk      (clk),
    .reset    (reset),
    .freeze   (hz.mem_busy),
    .load     (cnt_load_s),
    .load_val (md_load_val_s),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Priority mux: memory wait, then RV32M sequencing, then load-use.
  always_comb begin
    state_nxt_s   = state_r;
    cause_s       = NONE;
    cnt_load_s    = 1'b0;
    cnt_dec_s     = 1'b0;
    pc_hold_s     = 1'b0;
    ifid_hold_s   = 1'b0;
    idex_hold_s   = 1'b0;
    idex_flush_s  = 1'b0;
    exmem_hold_s  = 1'b0;
    exmem_flush_s = 1'b0;
    memwb_flush_s = 1'b0;
    muldiv_done_s = 1'b0;
    if (reset) begin
      state_nxt_s = IDLE;
    end else if (hz.mem_busy) begin
      cause_s       = MEM;
      pc_hold_s     = 1'b1;
      ifid_hold_s   = 1'b1;
      idex_hold_s   = 1'b1;
      exmem_hold_s  = 1'b1;
      memwb_flush_s = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (hz.ex_muldiv_valid && md_multi_s) begin
            cause_s       = MULDIV;
            pc_hold_s     = 1'b1;
            ifid_hold_s   = 1'b1;
            idex_hold_s   = 1'b1;
            exmem_flush_s = 1'b1;
            cnt_load_s    = 1'b1;
            state_nxt_s   = MD_BUSY;
          end else begin
            // Single-cycle RV32M completes in place and does not block load-use.
            muldiv_done_s = hz.ex_muldiv_valid;
            if (load_use_s) begin
              cause_s      = LOADUSE;
              pc_hold_s    = 1'b1;
              ifid_hold_s  = 1'b1;
              idex_flush_s = 1'b1;
            end else begin
              cause_s = NONE;
            end
          end
        end
        MD_BUSY: begin
          if (!cnt_zero_s) begin
            cause_s       = MULDIV;
            pc_hold_s     = 1'b1;
            ifid_hold_s   = 1'b1;
            idex_hold_s   = 1'b1;
            exmem_flush_s = 1'b1;
            cnt_dec_s     = 1'b1;
          end else begin
            muldiv_done_s = 1'b1;
            state_nxt_s   = IDLE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  assign hz.pc_hold     = pc_hold_s;
  assign hz.ifid_hold   = ifid_hold_s;
  assign hz.idex_hold   = idex_hold_s;
  assign hz.idex_flush  = idex_flush_s;
  assign hz.exmem_hold  = exmem_hold_s;
  assign hz.exmem_flush = exmem_flush_s;
  assign hz.memwb_flush = memwb_flush_s;
  assign hz.muldiv_done = muldiv_done_s;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] loaduse_cnt_r;
  logic [31:0] muldiv_cnt_r;
  logic [31:0] mem_cnt_r;

  // Per-cause stall cycle counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      loaduse_cnt_r <= 32'd0;
      muldiv_cnt_r  <= 32'd0;
      mem_cnt_r     <= 32'd0;
    end else begin
      case (cause_s)
        LOADUSE: loaduse_cnt_r <= loaduse_cnt_r + 32'd1;
        MULDIV:  muldiv_cnt_r  <= muldiv_cnt_r + 32'd1;
        MEM:     mem_cnt_r     <= mem_cnt_r + 32'd1;
        default: begin
          loaduse_cnt_r <= loaduse_cnt_r;
          muldiv_cnt_r  <= muldiv_cnt_r;
          mem_cnt_r     <= mem_cnt_r;
        end
      endcase
    end
  end

  assign loaduse_stall_cnt = loaduse_cnt_r;
  assign muldiv_stall_cnt  = muldiv_cnt_r;
  assign mem_stall_cnt     = mem_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: per-cycle reference model
// plus literal stall/done cycle counts for directed scenarios.
module tb_hazard_stall_controller;
  localparam int unsigned MUL_LAT = 1;
  localparam int unsigned DIV_LAT = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  int   md_rem = 0;
  int   obs_stall = 0;
  int   obs_done = 0;
  int   obs_idexf = 0;
  int   obs_memwb = 0;

  hazard_stall_controller_if hz_if ();

`ifdef STALL_PERF_CNT_EN
  logic [31:0] lu_cnt, md_cnt, mem_cnt;
`endif

  hazard_stall_controller #(.MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_if)
`ifdef STALL_PERF_CNT_EN
    ,
    .loaduse_stall_cnt (lu_cnt),
    .muldiv_stall_cnt  (md_cnt),
    .mem_stall_cnt     (mem_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit load_use_hit();
    return hz_if.ex_mem_read && (hz_if.ex_wb_addr != 5'd0) &&
           ((hz_if.id_uses_rs1 && hz_if.id_addr1 == hz_if.ex_wb_addr) ||
            (hz_if.id_uses_rs2 && hz_if.id_addr2 == hz_if.ex_wb_addr));
  endfunction

  // Model state: md_rem = EX occupancy cycles still to go for the running op.
  always @(posedge clk) begin
    int lat;
    lat = hz_if.ex_muldiv_is_div ? DIV_LAT : MUL_LAT;
    if (reset) md_rem = 0;
    else if (hz_if.mem_busy) md_rem = md_rem;
    else if (md_rem > 0) md_rem = md_rem - 1;
    else if (hz_if.ex_muldiv_valid && lat > 1) md_rem = lat - 1;
  end

  // Compare DUT outputs to the model every cycle.
  always @(negedge clk) begin
    logic [7:0] exp_v, got_v;
    int lat;
    lat = hz_if.ex_muldiv_is_div ? DIV_LAT : MUL_LAT;
    // bit order: pc ifid idex_h idex_f exmem_h exmem_f memwb_f done
    if (reset)                                 exp_v = 8'b0000_0000;
    else if (hz_if.mem_busy)                   exp_v = 8'b1110_1010;
    else if (md_rem > 1)                       exp_v = 8'b1110_0100;
    else if (md_rem == 1)                      exp_v = 8'b0000_0001;
    else if (hz_if.ex_muldiv_valid && lat > 1) exp_v = 8'b1110_0100;
    else begin
      exp_v = {7'b0, hz_if.ex_muldiv_valid};
      if (load_use_hit()) exp_v = exp_v | 8'b1101_0000;
    end
    got_v = {hz_if.pc_hold, hz_if.ifid_hold, hz_if.idex_hold, hz_if.idex_flush,
             hz_if.exmem_hold, hz_if.exmem_flush, hz_if.memwb_flush, hz_if.muldiv_done};
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL cycle_outputs t=%0t got=%b expected=%b", $time, got_v, exp_v);
    end
    if (got_v[7]) obs_stall++;
    if (got_v[0]) obs_done++;
    if (got_v[4]) obs_idexf++;
    if (got_v[1]) obs_memwb++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz_if.id_addr1 = 5'd0;  hz_if.id_addr2 = 5'd0;
    hz_if.id_uses_rs1 = 1'b0; hz_if.id_uses_rs2 = 1'b0;
    hz_if.ex_mem_read = 1'b0; hz_if.ex_wb_addr = 5'd0;
    hz_if.ex_muldiv_valid = 1'b0; hz_if.ex_muldiv_is_div = 1'b0;
    hz_if.mem_busy = 1'b0;
  endtask

  task automatic obs_clear();
    obs_stall = 0; obs_done = 0; obs_idexf = 0; obs_memwb = 0;
  endtask

  task automatic check_lit(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic load_use_case(input string name, input logic rd_load, input logic [4:0] wb,
                               input logic [4:0] a1, input logic u1,
                               input logic [4:0] a2, input logic u2, input int exp_stalls);
    obs_clear();
    hz_if.ex_mem_read = rd_load; hz_if.ex_wb_addr = wb;
    hz_if.id_addr1 = a1; hz_if.id_uses_rs1 = u1;
    hz_if.id_addr2 = a2; hz_if.id_uses_rs2 = u2;
    tick(1);
    clear_inputs();
    tick(2);
    check_lit({name, "_stall"}, obs_stall, exp_stalls);
    check_lit({name, "_bubble"}, obs_idexf, exp_stalls);
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    obs_clear();
    tick(2);
    check_lit("reset_quiet", obs_stall + obs_done + obs_memwb, 0);
    reset = 1'b0;
    tick(1);

    load_use_case("lu_rs1",     1'b1, 5'd5,  5'd5, 1'b1, 5'd0,  1'b0, 1);
    load_use_case("lu_x0",      1'b1, 5'd0,  5'd0, 1'b1, 5'd0,  1'b1, 0);
    load_use_case("lu_rs2",     1'b1, 5'd12, 5'd3, 1'b1, 5'd12, 1'b1, 1);
    load_use_case("lu_unused",  1'b1, 5'd7,  5'd7, 1'b0, 5'd7,  1'b0, 0);
    load_use_case("lu_notload", 1'b0, 5'd5,  5'd5, 1'b1, 5'd5,  1'b1, 0);

    // single-cycle MUL
    obs_clear();
    hz_if.ex_muldiv_valid = 1'b1; hz_if.ex_muldiv_is_div = 1'b0;
    tick(1);
    clear_inputs();
    tick(1);
    check_lit("mul_done", obs_done, 1);
    check_lit("mul_stall", obs_stall, 0);

    // two back-to-back DIVs
    obs_clear();
    hz_if.ex_muldiv_valid = 1'b1; hz_if.ex_muldiv_is_div = 1'b1;
    tick(32);
    check_lit("div1_stall", obs_stall, 31);
    check_lit("div1_done", obs_done, 1);
    tick(32);
    check_lit("div2_stall", obs_stall, 62);
    check_lit("div2_done", obs_done, 2);
    clear_inputs();
    tick(2);
    check_lit("div_after_stall", obs_stall, 62);

    // MEM_BUSY for 3 cycles with COUNT=10
    obs_clear();
    hz_if.ex_muldiv_valid = 1'b1; hz_if.ex_muldiv_is_div = 1'b1;
    tick(21);
    hz_if.mem_busy = 1'b1;
    tick(3);
    hz_if.mem_busy = 1'b0;
    check_lit("memfrz_memwb", obs_memwb, 3);
    check_lit("memfrz_nodone", obs_done, 0);
    tick(11);
    clear_inputs();
    tick(1);
    check_lit("memfrz_stall_total", obs_stall, 34);
    check_lit("memfrz_done", obs_done, 1);

    // reset abort at COUNT=7
    obs_clear();
    hz_if.ex_muldiv_valid = 1'b1; hz_if.ex_muldiv_is_div = 1'b1;
    tick(24);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    clear_inputs();
    tick(3);
    check_lit("abort_nodone", obs_done, 0);
    check_lit("abort_stall", obs_stall, 24);

    // MEM_BUSY while idle
    obs_clear();
    hz_if.mem_busy = 1'b1;
    tick(3);
    clear_inputs();
    tick(1);
    check_lit("idle_mem_memwb", obs_memwb, 3);

`ifdef STALL_PERF_CNT_EN
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_lit("perf_clr", int'(lu_cnt + md_cnt + mem_cnt), 0);
    hz_if.ex_mem_read = 1'b1; hz_if.ex_wb_addr = 5'd5;
    hz_if.id_addr1 = 5'd5; hz_if.id_uses_rs1 = 1'b1;
    tick(1);
    clear_inputs();
    hz_if.ex_muldiv_valid = 1'b1; hz_if.ex_muldiv_is_div = 1'b1;
    tick(32);
    clear_inputs();
    hz_if.mem_busy = 1'b1;
    tick(3);
    clear_inputs();
    tick(1);
    check_lit("perf_loaduse", int'(lu_cnt), 1);
    check_lit("perf_muldiv", int'(md_cnt), 31);
    check_lit("perf_mem", int'(mem_cnt), 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Central stall/bubble sequencer for the 5-stage RV32IM pipeline. Sits beside the EX operand forwarding unit.
- Resolves the hazards forwarding cannot cover:
  - load-use dependencies;
  - multi-cycle RV32M MUL/DIV occupancy of EX;
  - data-memory wait states.
- Drives hold (freeze) and flush (insert NOP) controls for PC and all pipeline registers.

Parameters:
MUL_LATENCY, 1, total cycles a MUL/MULH* op occupies EX (>=1)
DIV_LATENCY, 32, total cycles a DIV/DIVU/REM/REMU op occupies EX (>=1, <=64)

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
ID_ADDR1  input  5  rs1 of instruction in ID
ID_ADDR2  input  5  rs2 of instruction in ID
ID_USES_RS1  input  1  ID instruction reads rs1
ID_USES_RS2  input  1  ID instruction reads rs2
EX_MEM_READ  input  1  EX instruction is a load
EX_WB_ADDR  input  5  rd of EX instruction
EX_MULDIV_VALID  input  1  EX holds a valid RV32M op
EX_MULDIV_IS_DIV  input  1  that op is DIV/DIVU/REM/REMU
MEM_BUSY  input  1  data memory not ready this cycle
PC_HOLD  output  1  freeze PC
IFID_HOLD  output  1  freeze IF/ID
IDEX_HOLD  output  1  freeze ID/EX
IDEX_FLUSH  output  1  load NOP into ID/EX
EXMEM_HOLD  output  1  freeze EX/MEM
EXMEM_FLUSH  output  1  load NOP into EX/MEM
MEMWB_FLUSH  output  1  load NOP into MEM/WB
MULDIV_DONE  output  1  RV32M result valid in EX this cycle; EX/MEM may capture

Behaviour:
- FSM states: IDLE, MD_BUSY. Down-counter COUNT is 6 bits.
- All outputs are combinational from state, COUNT and inputs. Reset state is IDLE with COUNT=0.
- While RESET=1, every output is 0. Reset mid-MD_BUSY aborts the op: IDLE at the next edge, no MULDIV_DONE.
- Priority 1: MEM_BUSY=1.
  - Asserts PC_HOLD, IFID_HOLD, IDEX_HOLD, EXMEM_HOLD and MEMWB_FLUSH.
  - All other outputs are 0, including MULDIV_DONE.
  - FSM state and COUNT are frozen.
- Priority 2: RV32M sequencing. L = DIV_LATENCY if EX_MULDIV_IS_DIV, else MUL_LATENCY.
  - IDLE, EX_MULDIV_VALID=1, L=1: no stall; MULDIV_DONE=1; stay IDLE.
  - IDLE, EX_MULDIV_VALID=1, L>1:
    - asserts PC_HOLD, IFID_HOLD, IDEX_HOLD, EXMEM_FLUSH;
    - COUNT<=L-2; next state MD_BUSY.
  - MD_BUSY, COUNT!=0: same four stall outputs; COUNT<=COUNT-1.
  - MD_BUSY, COUNT==0: no stall; MULDIV_DONE=1; next state IDLE.
  - The op occupies EX for exactly L cycles; stall cycles = L-1.
  - An RV32M op immediately following re-enters from IDLE on the next cycle. No dead cycle.
  - EX_MULDIV_VALID is ignored in MD_BUSY.
- Priority 3: load-use, evaluated only in IDLE with no priority-1/2 stall.
  - Condition: EX_MEM_READ && EX_WB_ADDR!=0 && ((ID_USES_RS1 && ID_ADDR1==EX_WB_ADDR) || (ID_USES_RS2 && ID_ADDR2==EX_WB_ADDR)).
  - Response: PC_HOLD, IFID_HOLD, IDEX_FLUSH for one cycle. The bubble lets the load advance; forwarding resolves the rest.
- HOLD and FLUSH of the same register are never asserted together.
- x0 never triggers a load-use stall.

Optional Feature:
- Macro STALL_PERF_CNT_EN.
- Defined:
  - adds outputs LOADUSE_STALL_CNT[31:0], MULDIV_STALL_CNT[31:0], MEM_STALL_CNT[31:0];
  - each increments by 1 on every cycle its priority class is the active stall cause;
  - counters wrap at 2^32-1 -> 0 and clear on RESET.
- Undefined: ports and counter logic absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=1'b0, MD_BUSY=1'b1;
  - COUNT width constant (6);
  - the stall-cause enumeration (NONE, LOADUSE, MULDIV, MEM), also used by the perf counters.
- One natural sub-module, muldiv_latency_counter: load/decrement/zero-detect for COUNT, with freeze input driven by MEM_BUSY.
- Load-use detect and priority muxing stay in the top.

Test Plan:
- Load-use: EX_MEM_READ=1, EX_WB_ADDR=5, ID_ADDR1=5, ID_USES_RS1=1 -> PC_HOLD=IFID_HOLD=IDEX_FLUSH=1 for exactly 1 cycle. Same stimulus with EX_WB_ADDR=0 -> no stall.
- DIV, DIV_LATENCY=32: EX_MULDIV_VALID=1, IS_DIV=1 held -> stall outputs high for 31 cycles; MULDIV_DONE=1 on cycle 32 only. Back-to-back second DIV -> another 31 stall cycles with no gap.
- MUL, MUL_LATENCY=1: EX_MULDIV_VALID=1, IS_DIV=0 -> zero stall cycles; MULDIV_DONE=1 same cycle.
- MEM_BUSY=1 for 3 cycles during MD_BUSY at COUNT=10:
  - full freeze and MEMWB_FLUSH for those 3 cycles;
  - COUNT still 10 afterwards;
  - total DIV stall = 31 + 3.
- RESET=1 at MD_BUSY COUNT=7 -> all outputs 0 that cycle; IDLE next cycle; MULDIV_DONE never asserted for the aborted op.
- With STALL_PERF_CNT_EN: one load-use, one 32-cycle DIV, 3 MEM_BUSY cycles -> counters read 1, 31, 3.
